// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
package fetch_pkg;

   localparam int PC_W        = 32;
   localparam int INSTR_W     = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: circular entry array with FETCH_WIDTH write ports at
// consecutive addresses from the tail and FETCH_WIDTH read ports from the head.
// Addresses wrap naturally because DEPTH is a power of two.
module fetch_queue_storage #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int ENTRY_W     = 64,
   parameter int PW          = $clog2(DEPTH)
) (
   input  logic                           clk_i,
   input  logic [FETCH_WIDTH-1:0]         we_i,
   input  logic [PW-1:0]                  waddr_i,
   input  logic [FETCH_WIDTH*ENTRY_W-1:0] wdata_i,
   input  logic [PW-1:0]                  raddr_i,
   output logic [FETCH_WIDTH*ENTRY_W-1:0] rdata_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   // Write the enabled slots in order starting at the tail address.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (we_i[k]) begin
            mem_q[waddr_i + PW'(k)] <= wdata_i[k*ENTRY_W +: ENTRY_W];
         end
      end
   end

   for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_rd
      assign rdata_o[k*ENTRY_W +: ENTRY_W] = mem_q[raddr_i + PW'(k)];
   end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: owns the PC, issues FETCH_WIDTH-wide imem reads, queues the
// fetched instructions and hands in-order groups to decode.
// Optional stall counter enabled by defining FETCH_BUFFER_PERF_EN.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int                 PC_SIZE     = 32,
   parameter int                 INSTR_SIZE  = 32,
   parameter int                 FETCH_WIDTH = 2,
   parameter int                 QUEUE_DEPTH = 8,
   parameter logic [PC_SIZE-1:0] RESET_PC    = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   output logic                              imem_req_o,
   output logic [PC_SIZE-1:0]                imem_addr_o,
   input  logic [FETCH_WIDTH*INSTR_SIZE-1:0] imem_rdata_i,
   input  logic [FETCH_WIDTH-1:0]            imem_done_i,
   input  logic                              redirect_i,
   input  logic [PC_SIZE-1:0]                redirect_pc_i,
   output logic [FETCH_WIDTH-1:0]            deq_valid_o,
   output logic [FETCH_WIDTH*INSTR_SIZE-1:0] deq_instr_o,
   output logic [FETCH_WIDTH*PC_SIZE-1:0]    deq_pc_o,
   input  logic                              deq_ready_i,
   output logic [$clog2(QUEUE_DEPTH):0]      count_o,
   output logic                              end_o,
   output logic [31:0]                       stall_cycles_o
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = PC_SIZE + INSTR_SIZE;

   fetch_state_e             state_q, state_d;
   logic [PC_SIZE-1:0]       pc_q, pc_d;
   logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]            count_q, count_d;
   logic [CW-1:0]            enq_n, deq_n, avail;
   logic                     req;
   logic [FETCH_WIDTH-1:0]   we;
   logic [FETCH_WIDTH*EW-1:0] wdata, rdata;

   // State, PC, pointers and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Next state: redirect restarts fetch, any done bit on a request ends it.
   always_comb begin
      state_d = state_q;
      if (redirect_i) begin
         state_d = RUN;
      end else if (req && (|imem_done_i)) begin
         state_d = DONE;
      end
   end

   // FSM outputs: request needs room for a full group; end needs an empty queue.
   always_comb begin
      req   = (state_q == RUN) && ((CW'(QUEUE_DEPTH) - count_q) >= CW'(FETCH_WIDTH)) && !redirect_i;
      end_o = (state_q == DONE) && (count_q == '0);
   end

   // Slots enqueued: those below the lowest done bit, only on a request.
   always_comb begin
      enq_n = CW'(FETCH_WIDTH);
      for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
         if (imem_done_i[k]) begin
            enq_n = CW'(k);
         end
      end
      if (!req) begin
         enq_n = '0;
      end
   end

   // Pops take every presented slot; redirect suppresses both pop and push.
   always_comb begin
      avail = (count_q >= CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : count_q;
      deq_n = (deq_ready_i && !redirect_i) ? avail : '0;
      if (redirect_i) begin
         pc_d    = redirect_pc_i & ~PC_SIZE'(INSTR_BYTES - 1);
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         pc_d    = req ? pc_q + PC_SIZE'(INSTR_BYTES * FETCH_WIDTH) : pc_q;
         head_d  = head_q + PW'(deq_n);
         tail_d  = tail_q + PW'(enq_n);
         count_d = count_q + enq_n - deq_n;
      end
   end

   for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
      assign we[k] = CW'(k) < enq_n;
      assign wdata[k*EW +: EW] = {pc_q + PC_SIZE'(INSTR_BYTES * k),
                                  imem_rdata_i[k*INSTR_SIZE +: INSTR_SIZE]};
      assign deq_valid_o[k] = count_q > CW'(k);
      assign deq_pc_o[k*PC_SIZE +: PC_SIZE] =
         deq_valid_o[k] ? rdata[k*EW + INSTR_SIZE +: PC_SIZE] : '0;
      assign deq_instr_o[k*INSTR_SIZE +: INSTR_SIZE] =
         deq_valid_o[k] ? rdata[k*EW +: INSTR_SIZE] : '0;
   end

   fetch_queue_storage #(
      .DEPTH       (QUEUE_DEPTH),
      .FETCH_WIDTH (FETCH_WIDTH),
      .ENTRY_W     (EW),
      .PW          (PW)
   ) u_storage (
      .clk_i   (clk_i),
      .we_i    (we),
      .waddr_i (tail_q),
      .wdata_i (wdata),
      .raddr_i (head_q),
      .rdata_o (rdata)
   );

   assign imem_req_o  = req;
   assign imem_addr_o = pc_q;
   assign count_o     = count_q;

`ifdef FETCH_BUFFER_PERF_EN
   logic [31:0] stall_q;

   // Count cycles where fetch wanted to run but had no room; saturates.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_q <= '0;
      end else if ((state_q == RUN) && !redirect_i && !req && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

endmodule
